execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the five-stage cqu_mips pipeline; sits directly upstream of memory_access and drives its alu_result/mem_addr/write_data/write_reg and control inputs through an internal EX/MEM output register.
- Performs single-cycle ALU ops, single-cycle MULT/MULTU, an iterative 32-step DIV/DIVU, and owns the HI/LO registers.
- Raises busy to freeze upstream stages while a division runs.

Parameters:
- DIV_STEPS, 32, quotient bits produced per division (one per cycle); fixed by the 32-bit datapath.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit hold: EX/MEM output register keeps its value; no new op issues
- valid_in  in  1  ID/EX slot holds a real instruction
- alu_ctrl  in  5  operation code (package encoding)
- src_a  in  32  operand A (forwarded rs, or shamt zero-extended for immediate shifts)
- src_b  in  32  operand B (forwarded rt)
- imm  in  32  sign/zero-extended immediate
- alu_src  in  1  1: B operand = imm, 0: B operand = src_b
- write_reg_in  in  5  destination register
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  decode control
- alu_result  out  32  registered ALU/MF result
- mem_addr  out  32  registered; equals alu_result
- write_data  out  32  registered src_b (store data)
- write_reg  out  5  registered destination
- reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out  out  1 each  registered control
- overflow  out  1  registered signed overflow flag of ADD/SUB
- busy  out  1  combinational; division in progress, upstream must hold

Behaviour:
- Reset (rst=0, async): all outputs 0, HI=LO=0, FSM=IDLE, counter=0.
- Output register update: loads every posedge when stall=0 and busy=0. When busy=1 and stall=0 it loads a bubble (all control outputs 0, data 0). When stall=1 it holds.
- ALU latency: 1 cycle (operands in EX cycle N, result at outputs after edge N).
- ALU ops:
  - ADD/SUB: 32-bit wrap. Signed overflow sets overflow=1 and forces reg_write_out=0.
  - ADDU/SUBU: never flag overflow.
  - SLT signed, SLTU unsigned; result 0 or 1.
  - SLL/SRL/SRA: shift B by A[4:0].
  - LUI: result = {B[15:0],16'h0}.
- MULT/MULTU: 64-bit product written to {HI,LO} at the end of the EX cycle; reg_write_out=0.
- MFHI/MFLO: result = current HI/LO. This includes a value written by a MULT on the immediately preceding edge, so there is no hazard.
- MTHI/MTLO: HI/LO <= src_a.
- HI/LO writes occur only when the op is valid and stall=0.
- Divider FSM:
  - IDLE: valid DIV/DIVU with stall=0 asserts busy in that same cycle, latches |dividend|, |divisor| and result signs, counter=0, goes to RUN.
  - RUN: busy=1; one restoring step per cycle regardless of stall; counter++; counter==31 goes to DONE.
  - DONE: busy=0. When stall=0: HI<=remainder and LO<=quotient (sign-corrected), the instruction retires as a bubble, go to IDLE. When stall=1: stay in DONE.
  - Total busy = 33 cycles from issue.
- Division sign rules: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- Divide by zero is not trapped; it takes the natural restoring result: quotient=FFFFFFFF (before sign fix), remainder=|dividend|.
- Reset mid-division aborts: IDLE, busy=0, HI/LO=0.
- valid_in=0 produces a bubble and starts no division.

Decomposition:
- Package cqu_mips_pkg holds the ALU_* 5-bit opcode localparams:
  - ADD 00000, ADDU 00001, SUB 00010, SUBU 00011
  - AND 00100, OR 00101, XOR 00110, NOR 00111
  - SLT 01000, SLTU 01001, SLL 01010, SRL 01011, SRA 01100, LUI 01101
  - MULT 10000, MULTU 10001, DIV 10010, DIVU 10011
  - MFHI 10100, MFLO 10101, MTHI 10110, MTLO 10111
- The package also holds the divider state encodings IDLE/RUN/DONE.
- One sub-module: div_iter, containing the FSM, counter, restoring shift-subtract datapath and sign correction, with a start/busy/done handshake.

Test Plan:
- ADD 7FFFFFFF+00000001 -> alu_result 80000000, overflow=1, reg_write_out=0. ADDU with the same operands -> overflow=0, reg_write_out=1.
- SLT FFFFFFFF,00000001 -> 1; SLTU with the same operands -> 0; SRA 80000000 by 4 -> F8000000.
- MULT FFFFFFFD x 00000005, next cycle MFHI then MFLO -> FFFFFFFF then FFFFFFF1.
- DIV FFFFFFF9 / 00000002 -> busy high exactly 33 cycles, then LO=FFFFFFFD, HI=FFFFFFFF; EX/MEM carries bubbles throughout.
- DIVU 00000009 / 0 -> LO=FFFFFFFF, HI=00000009. Assert stall during DONE for 3 cycles -> HI/LO unchanged until stall drops.
- rst low at RUN counter=10 -> busy=0 immediately, HI=LO=0. A following DIVU 64/8 completes with LO=00000008, HI=0.

Source files
------------

// File: rtl/cqu_mips_pkg.sv
// Shared encodings for the cqu_mips execute stage: ALU opcodes and divider states.
package cqu_mips_pkg;

  localparam int DIV_STEPS = 32;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_ADDU  = 5'b00001;
  localparam logic [4:0] ALU_SUB   = 5'b00010;
  localparam logic [4:0] ALU_SUBU  = 5'b00011;
  localparam logic [4:0] ALU_AND   = 5'b00100;
  localparam logic [4:0] ALU_OR    = 5'b00101;
  localparam logic [4:0] ALU_XOR   = 5'b00110;
  localparam logic [4:0] ALU_NOR   = 5'b00111;
  localparam logic [4:0] ALU_SLT   = 5'b01000;
  localparam logic [4:0] ALU_SLTU  = 5'b01001;
  localparam logic [4:0] ALU_SLL   = 5'b01010;
  localparam logic [4:0] ALU_SRL   = 5'b01011;
  localparam logic [4:0] ALU_SRA   = 5'b01100;
  localparam logic [4:0] ALU_LUI   = 5'b01101;
  localparam logic [4:0] ALU_MULT  = 5'b10000;
  localparam logic [4:0] ALU_MULTU = 5'b10001;
  localparam logic [4:0] ALU_DIV   = 5'b10010;
  localparam logic [4:0] ALU_DIVU  = 5'b10011;
  localparam logic [4:0] ALU_MFHI  = 5'b10100;
  localparam logic [4:0] ALU_MFLO  = 5'b10101;
  localparam logic [4:0] ALU_MTHI  = 5'b10110;
  localparam logic [4:0] ALU_MTLO  = 5'b10111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// signs reapplied on the way out. Holds its result in DONE while hold_i is high.
module div_iter
  import cqu_mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        hold_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [32:0] shifted, trial;
  logic        dvd_neg, dvs_neg;

  assign dvd_neg = signed_i & dividend_i[31];
  assign dvs_neg = signed_i & divisor_i[31];
  // Remainder is always below the divisor, so trial[32] is a clean borrow flag.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          busy_o    = 1'b1;
          state_d   = DIV_RUN;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = dvd_neg ? -dividend_i : dividend_i;
          dvs_d     = dvs_neg ? -divisor_i : divisor_i;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
        end
      end
      DIV_RUN: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == LAST_STEP) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        done_o = 1'b1;
        if (!hold_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign quotient_o  = neg_quo_q ? -quo_q : quo_q;
  assign remainder_o = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage of cqu_mips: single-cycle ALU and multiply, iterative divide,
// HI/LO ownership, and the EX/MEM output register.
module execute_stage
  import cqu_mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        valid_in,
  input  logic [4:0]  alu_ctrl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] imm,
  input  logic        alu_src,
  input  logic [4:0]  write_reg_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  output logic [31:0] alu_result,
  output logic [31:0] mem_addr,
  output logic [31:0] write_data,
  output logic [4:0]  write_reg,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        mem_to_reg_out,
  output logic        overflow,
  output logic        busy
);

  logic [31:0] op_b, sum, diff, alu_res, hi_q, lo_q, quotient, remainder;
  logic [63:0] prod_s, prod_u;
  logic        ovf, no_wr, is_div, div_start, div_busy, div_done, bubble;

  logic [31:0] res_q, wdata_q;
  logic [4:0]  wreg_q;
  logic        rw_q, mr_q, mw_q, m2r_q, ovf_q;

  assign op_b   = alu_src ? imm : src_b;
  assign sum    = src_a + op_b;
  assign diff   = src_a - op_b;
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'b0, src_a} * {32'b0, op_b};

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    no_wr   = 1'b0;
    case (alu_ctrl)
      ALU_ADD:  begin
        alu_res = sum;
        ovf     = (src_a[31] == op_b[31]) && (sum[31] != src_a[31]);
      end
      ALU_ADDU: alu_res = sum;
      ALU_SUB:  begin
        alu_res = diff;
        ovf     = (src_a[31] != op_b[31]) && (diff[31] != src_a[31]);
      end
      ALU_SUBU: alu_res = diff;
      ALU_AND:  alu_res = src_a & op_b;
      ALU_OR:   alu_res = src_a | op_b;
      ALU_XOR:  alu_res = src_a ^ op_b;
      ALU_NOR:  alu_res = ~(src_a | op_b);
      ALU_SLT:  alu_res = {31'b0, $signed(src_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, src_a < op_b};
      ALU_SLL:  alu_res = op_b << src_a[4:0];
      ALU_SRL:  alu_res = op_b >> src_a[4:0];
      ALU_SRA:  alu_res = $signed(op_b) >>> src_a[4:0];
      ALU_LUI:  alu_res = {op_b[15:0], 16'h0000};
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      ALU_MULT, ALU_MULTU, ALU_MTHI, ALU_MTLO: no_wr = 1'b1;
      default:  alu_res = '0;
    endcase
  end

  assign is_div    = is_div_op(alu_ctrl);
  assign div_start = valid_in & is_div & ~stall;
  assign busy      = div_busy;
  // A divide occupies the slot until DONE; its retirement is itself a bubble.
  assign bubble    = div_busy | ~valid_in | is_div;

  div_iter u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .signed_i    (alu_ctrl == ALU_DIV),
    .hold_i      (stall),
    .dividend_i  (src_a),
    .divisor_i   (op_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_done && !stall) begin
      hi_q <= remainder;
      lo_q <= quotient;
    end else if (valid_in && !stall && !div_busy) begin
      case (alu_ctrl)
        ALU_MULT:  {hi_q, lo_q} <= prod_s;
        ALU_MULTU: {hi_q, lo_q} <= prod_u;
        ALU_MTHI:  hi_q <= src_a;
        ALU_MTLO:  lo_q <= src_a;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!stall) begin
      if (bubble) begin
        res_q   <= '0;
        wdata_q <= '0;
        wreg_q  <= '0;
        rw_q    <= 1'b0;
        mr_q    <= 1'b0;
        mw_q    <= 1'b0;
        m2r_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        res_q   <= alu_res;
        wdata_q <= src_b;
        wreg_q  <= write_reg_in;
        rw_q    <= reg_write_in & ~ovf & ~no_wr;
        mr_q    <= mem_read_in;
        mw_q    <= mem_write_in;
        m2r_q   <= mem_to_reg_in;
        ovf_q   <= ovf;
      end
    end
  end

  assign alu_result     = res_q;
  assign mem_addr       = res_q;
  assign write_data     = wdata_q;
  assign write_reg      = wreg_q;
  assign reg_write_out  = rw_q;
  assign mem_read_out   = mr_q;
  assign mem_write_out  = mw_q;
  assign mem_to_reg_out = m2r_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected EX/MEM contents are queued at
// issue and popped one cycle later; divides are tracked cycle by cycle.
module tb_execute_stage;
  import cqu_mips_pkg::*;

  logic        clk, rst, stall, valid_in, alu_src;
  logic [4:0]  alu_ctrl, write_reg_in;
  logic [31:0] src_a, src_b, imm;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic [31:0] alu_result, mem_addr, write_data;
  logic [4:0]  write_reg;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
  logic        overflow, busy;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .valid_in(valid_in),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .imm(imm),
    .alu_src(alu_src), .write_reg_in(write_reg_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_result(alu_result), .mem_addr(mem_addr), .write_data(write_data),
    .write_reg(write_reg), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        rw;
    logic        ovf;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        mw;
    logic        mr;
    bit          chk_res;
  } exp_t;

  exp_t       sb[$];
  exp_t       last_exp;
  int         checks   = 0;
  int         failures = 0;
  logic [4:0] wreg_n   = 5'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    last_exp = e;
    if (e.chk_res) begin
      check({tag, "_res"},  alu_result, e.res);
      check({tag, "_addr"}, mem_addr,   e.res);
    end
    check({tag, "_rw"},    32'(reg_write_out),  32'(e.rw));
    check({tag, "_ovf"},   32'(overflow),       32'(e.ovf));
    check({tag, "_wreg"},  32'(write_reg),      32'(e.wreg));
    check({tag, "_wdata"}, write_data,          e.wdata);
    check({tag, "_mw"},    32'(mem_write_out),  32'(e.mw));
    check({tag, "_mr"},    32'(mem_read_out),   32'(e.mr));
    check({tag, "_m2r"},   32'(mem_to_reg_out), 32'(e.mr));
  endtask

  // mem[0]: store, mem[1]: load (mem_read + mem_to_reg)
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a, b,
                       input logic [31:0] imm_v, input logic src_sel, input logic rw_in,
                       input logic [1:0] mem, input logic [31:0] exp_res,
                       input logic exp_rw, input logic exp_ovf, input bit chk_res);
    @(negedge clk);
    valid_in = 1'b1; stall = 1'b0; alu_ctrl = op; src_a = a; src_b = b;
    imm = imm_v; alu_src = src_sel; write_reg_in = wreg_n; reg_write_in = rw_in;
    mem_write_in = mem[0]; mem_read_in = mem[1]; mem_to_reg_in = mem[1];
    sb.push_back('{res: exp_res, rw: exp_rw, ovf: exp_ovf, wreg: wreg_n, wdata: b,
                   mw: mem[0], mr: mem[1], chk_res: chk_res});
    wreg_n = wreg_n + 5'd1;
    #1 check({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1 compare_out(tag);
  endtask

  task automatic bubble_issue(input string tag, input logic [4:0] op, input logic [31:0] a, b);
    @(negedge clk);
    valid_in = 1'b0; stall = 1'b0; alu_ctrl = op; src_a = a; src_b = b;
    imm = '0; alu_src = 1'b0; write_reg_in = 5'd31; reg_write_in = 1'b1;
    mem_write_in = 1'b1; mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
    sb.push_back('{res: 32'd0, rw: 1'b0, ovf: 1'b0, wreg: 5'd0, wdata: 32'd0,
                   mw: 1'b0, mr: 1'b0, chk_res: 1'b1});
    #1 check({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1 compare_out(tag);
  endtask

  task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a, b,
                         input int done_stall);
    int busy_cycles = 0;
    int guard       = 0;
    @(negedge clk);
    valid_in = 1'b1; stall = 1'b0; alu_ctrl = op; src_a = a; src_b = b;
    imm = '0; alu_src = 1'b0; write_reg_in = 5'd9; reg_write_in = 1'b1;
    mem_write_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0;
    #1;
    while (busy && guard < 200) begin
      busy_cycles++;
      guard++;
      @(posedge clk); #1;
      check({tag, "_bub_rw"},   32'(reg_write_out), 32'd0);
      check({tag, "_bub_res"},  alu_result, 32'd0);
      check({tag, "_bub_wreg"}, 32'(write_reg), 32'd0);
      @(negedge clk); #1;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
    if (done_stall > 0) begin
      stall = 1'b1;
      for (int i = 0; i < done_stall; i++) begin
        @(posedge clk); #1;
        check({tag, "_done_stall_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_stall_rw"},   32'(reg_write_out), 32'd0);
        @(negedge clk); #1;
      end
      stall = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, "_retire_rw"},  32'(reg_write_out), 32'd0);
    check({tag, "_retire_res"}, alu_result, 32'd0);
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, b);
    case (op)
      ALU_ADDU: return a + b;
      ALU_SUBU: return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLL:  return b << a[4:0];
      ALU_SRL:  return b >> a[4:0];
      default:  return 32'd0;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rops [8];
    logic [4:0] op;
    logic [31:0] ra, rb;
    rops = '{ALU_ADDU, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL};

    // Reset with a live instruction on the inputs: outputs must stay cleared.
    rst = 1'b0; stall = 1'b0; valid_in = 1'b1; alu_ctrl = ALU_ADDU;
    src_a = 32'd1; src_b = 32'd1; imm = '0; alu_src = 1'b0; write_reg_in = 5'd4;
    reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1; mem_to_reg_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res",   alu_result, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_rw",    32'(reg_write_out), 32'd0);
    check("rst_mw",    32'(mem_write_out), 32'd0);
    check("rst_wreg",  32'(write_reg), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    @(negedge clk) rst = 1'b1;

    issue("add_ovf",  ALU_ADD,  32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 32'h80000000, 1'b0, 1'b1, 1'b1);
    issue("addu",     ALU_ADDU, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 32'h80000000, 1'b1, 1'b0, 1'b1);
    issue("sub_ovf",  ALU_SUB,  32'h80000000, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    issue("slt",      ALU_SLT,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 32'h1, 1'b1, 1'b0, 1'b1);
    issue("sltu",     ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
    issue("sra",      ALU_SRA,  32'd4, 32'h80000000, 32'h0, 1'b0, 1'b1, 2'b00, 32'hF8000000, 1'b1, 1'b0, 1'b1);
    issue("srl",      ALU_SRL,  32'd4, 32'h80000000, 32'h0, 1'b0, 1'b1, 2'b00, 32'h08000000, 1'b1, 1'b0, 1'b1);
    issue("sll31",    ALU_SLL,  32'd31, 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 32'h80000000, 1'b1, 1'b0, 1'b1);
    issue("lui",      ALU_LUI,  32'h0, 32'h55, 32'h0000ABCD, 1'b1, 1'b1, 2'b00, 32'hABCD0000, 1'b1, 1'b0, 1'b1);
    issue("store",    ALU_ADDU, 32'h100, 32'hCAFE0001, 32'hFFFFFFFC, 1'b1, 1'b0, 2'b01, 32'h000000FC, 1'b0, 1'b0, 1'b1);
    issue("load",     ALU_ADDU, 32'h200, 32'h0, 32'h00000010, 1'b1, 1'b1, 2'b10, 32'h00000210, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      op = rops[$urandom_range(0, 7)];
      ra = $urandom();
      rb = $urandom();
      issue("rand", op, ra, rb, 32'h0, 1'b0, 1'b1, 2'b00, model(op, ra, rb), 1'b1, 1'b0, 1'b1);
    end

    issue("mthi", ALU_MTHI, 32'h11111111, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("mtlo", ALU_MTLO, 32'h22222222, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

    // Stall: EX/MEM holds and a stalled MTHI must not write HI.
    issue("pre_stall", ALU_ADDU, 32'd2, 32'd3, 32'h0, 1'b0, 1'b1, 2'b00, 32'd5, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    stall = 1'b1; alu_ctrl = ALU_MTHI; src_a = 32'hDEADBEEF; src_b = 32'h10;
    sb.push_back(last_exp);
    @(posedge clk); #1 compare_out("stall_hold");
    bubble_issue("bub_mtlo", ALU_MTLO, 32'h33333333, 32'h0);
    bubble_issue("bub_div",  ALU_DIV,  32'h64, 32'h5);
    issue("mfhi_mt", ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h11111111, 1'b1, 1'b0, 1'b1);
    issue("mflo_mt", ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h22222222, 1'b1, 1'b0, 1'b1);

    run_div("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'h2, 0);
    issue("mfhi_div", ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
    issue("mflo_div", ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b1);

    issue("mult",      ALU_MULT, 32'hFFFFFFFD, 32'h5, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("mfhi_mult", ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
    issue("mflo_mult", ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFF1, 1'b1, 1'b0, 1'b1);
    issue("multu",     ALU_MULTU, 32'hFFFFFFFF, 32'h2, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("mfhi_mulu", ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h00000001, 1'b1, 1'b0, 1'b1);
    issue("mflo_mulu", ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1);

    run_div("divu_zero", ALU_DIVU, 32'h9, 32'h0, 3);
    issue("mfhi_dz", ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h00000009, 1'b1, 1'b0, 1'b1);
    issue("mflo_dz", ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);

    // Reset while the divider is at RUN step 10.
    @(negedge clk);
    valid_in = 1'b1; stall = 1'b0; alu_ctrl = ALU_DIVU; src_a = 32'd100; src_b = 32'd3;
    alu_src = 1'b0; reg_write_in = 1'b1; mem_write_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0;
    #1 check("abort_start_busy", 32'(busy), 32'd1);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    valid_in = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_res",  alu_result, 32'd0);
    @(negedge clk) rst = 1'b1;
    issue("mfhi_abort", ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
    issue("mflo_abort", ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);

    run_div("divu_64_8", ALU_DIVU, 32'd64, 32'd8, 0);
    issue("mfhi_64", ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
    issue("mflo_64", ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 32'h8, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
